lcd_rect_sequencer: RTL and testbench

Command/data sequencer for the SPI LCD path, sitting between the top level and the SPI byte transmitter. After reset it pulses the panel reset and sends the init sequence. It then accepts rectangle-fill requests and emits CASET, PASET, RAMWR and 2·w·h RGB565 pixel bytes to the transmitter through a valid/ready byte handshake. It also drives panel reset and the backlight LED.

---
 rtl/lcd_seq_pkg.sv | 67 ++++++
 rtl/lcd_delay_timer.sv | 37 +++
 rtl/lcd_rect_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_lcd_rect_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared definitions for the SPI LCD command/data sequencer.
//   - panel command opcodes and the COLMOD pixel-format argument
//   - sequencer state enum
//   - init_entry_t: one outgoing byte tagged with its D/C flag
//   - helpers that map a per-state byte index to the byte to send
package lcd_seq_pkg;

  localparam logic [7:0] CMD_SLPOUT   = 8'h11;
  localparam logic [7:0] CMD_COLMOD   = 8'h3A;
  localparam logic [7:0] COLMOD_16BPP = 8'h55;
  localparam logic [7:0] CMD_DISPON   = 8'h29;
  localparam logic [7:0] CMD_CASET    = 8'h2A;
  localparam logic [7:0] CMD_PASET    = 8'h2B;
  localparam logic [7:0] CMD_RAMWR    = 8'h2C;

  localparam int INIT_LEN = 3;

  typedef enum logic [3:0] {
    ST_RST_LOW,
    ST_RST_HIGH,
    ST_SLPOUT,
    ST_SLP_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_PIXELS,
    ST_FINISH
  } state_e;

  // dc: 0 = command, 1 = data
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } init_entry_t;

  // Post-SLPOUT init table: COLMOD 16bpp, then display on.
  function automatic init_entry_t init_entry(input logic [2:0] idx);
    init_entry_t e;
    case (idx)
      3'd0:    begin e.dc = 1'b0; e.data = CMD_COLMOD;   end
      3'd1:    begin e.dc = 1'b1; e.data = COLMOD_16BPP; end
      3'd2:    begin e.dc = 1'b0; e.data = CMD_DISPON;   end
      default: begin e.dc = 1'b0; e.data = 8'h00;        end
    endcase
    return e;
  endfunction

  // CASET/PASET frame: command, then start and end address, MSB first.
  function automatic init_entry_t addr_entry(input logic [7:0]  cmd,
                                             input logic [2:0]  idx,
                                             input logic [15:0] a0,
                                             input logic [15:0] a1);
    init_entry_t e;
    case (idx)
      3'd0:    begin e.dc = 1'b0; e.data = cmd;       end
      3'd1:    begin e.dc = 1'b1; e.data = a0[15:8];  end
      3'd2:    begin e.dc = 1'b1; e.data = a0[7:0];   end
      3'd3:    begin e.dc = 1'b1; e.data = a1[15:8];  end
      3'd4:    begin e.dc = 1'b1; e.data = a1[7:0];   end
      default: begin e.dc = 1'b0; e.data = 8'h00;     end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: load / count-down / expire counter.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset; reloads the counter so the
//              state entered on reset is timed from reset release
//   i_load     reload with DELAY-1 (asserted on the edge entering a delay state)
//   o_expired  high on the last of the DELAY cycles counted from the load
module lcd_delay_timer #(
  parameter int DELAY = 1_350_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expired
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(DELAY - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load)
      cnt_d = LOAD_VAL;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= LOAD_VAL;
    else       cnt_q <= cnt_d;
  end

  assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/lcd_rect_sequencer.sv
// lcd_rect_sequencer: command/data sequencer for the SPI LCD.
// After reset it holds the panel in reset, releases it, sends SLPOUT, waits,
// sends COLMOD/DISPON and turns the backlight on. In IDLE it accepts
// rectangle fills and streams CASET, PASET, RAMWR and 2*w*h colour bytes
// over a valid/ready byte handshake.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start                       request strobe (sampled only in IDLE)
//   i_x, i_y, i_w, i_h, i_color   rectangle corner, size, RGB565 colour
//   o_data, o_dc, o_valid         byte to transmitter (dc 0 = cmd, 1 = data)
//   i_ready                       transmitter accepts the byte this cycle
//   o_lcd_rst                     panel reset, active-low
//   o_led                         backlight, on once init completes
//   o_busy                        high outside IDLE/FINISH
//   o_done, o_err                 end-of-request pulse; o_err marks a reject
//
// Build option: LCD_SEQ_CLIP_EN clips rectangles that run past the panel
// edge instead of rejecting them.
module lcd_rect_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int DELAY  = 1_350_000,
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic [15:0] i_w,
  input  logic [15:0] i_h,
  input  logic [15:0] i_color,
  output logic [7:0]  o_data,
  output logic        o_dc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_lcd_rst,
  output logic        o_led,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int PIX_W = $clog2(WIDTH * HEIGHT + 1);
  localparam logic [16:0] WIDTH17  = 17'(WIDTH);
  localparam logic [16:0] HEIGHT17 = 17'(HEIGHT);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;      // byte index within INIT/CASET/PASET
  logic             half_q, half_d;    // 0: colour MSB next, 1: LSB next
  logic [PIX_W-1:0] pix_q, pix_d;      // pixels still to send
  logic [15:0]      x0_q, x0_d, x1_q, x1_d;
  logic [15:0]      y0_q, y0_d, y1_q, y1_d;
  logic [15:0]      color_q, color_d;
  logic             err_q, err_d;
  logic             led_q, led_d;

  logic tmr_load, tmr_expired;
  logic xfer;

  lcd_delay_timer #(.DELAY(DELAY)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (tmr_load),
    .o_expired (tmr_expired)
  );

  // ---------------------------------------------------------------------
  // Request check and geometry, evaluated on the live inputs; only used on
  // the accepting cycle, where the results are latched.
  // ---------------------------------------------------------------------
  logic [16:0]      x_end, y_end;
  logic             ovf_x, ovf_y, bad_req, reject;
  logic [15:0]      w_eff, h_eff;
  logic [16:0]      x1_full, y1_full;
  logic [PIX_W-1:0] pix_total;
  logic             unused_bits;

  always_comb begin
    x_end   = {1'b0, i_x} + {1'b0, i_w};
    y_end   = {1'b0, i_y} + {1'b0, i_h};
    ovf_x   = (x_end > WIDTH17);
    ovf_y   = (y_end > HEIGHT17);
    bad_req = (i_w == '0) || (i_h == '0) ||
              ({1'b0, i_x} >= WIDTH17) || ({1'b0, i_y} >= HEIGHT17);
`ifdef LCD_SEQ_CLIP_EN
    reject  = bad_req;
    w_eff   = ovf_x ? 16'(WIDTH17  - {1'b0, i_x}) : i_w;
    h_eff   = ovf_y ? 16'(HEIGHT17 - {1'b0, i_y}) : i_h;
`else
    reject  = bad_req || ovf_x || ovf_y;
    w_eff   = i_w;
    h_eff   = i_h;
`endif
    x1_full = {1'b0, i_x} + {1'b0, w_eff} - 17'd1;
    y1_full = {1'b0, i_y} + {1'b0, h_eff} - 17'd1;
    // Truncation is exact for accepted requests: w_eff*h_eff <= WIDTH*HEIGHT.
    pix_total = PIX_W'(w_eff) * PIX_W'(h_eff);
  end

  // Accepted end addresses always fit in 16 bits.
  assign unused_bits = x1_full[16] ^ y1_full[16];

  // ---------------------------------------------------------------------
  // Byte presented to the transmitter: purely a function of registered
  // state, so it is stable for as long as the handshake stalls.
  // ---------------------------------------------------------------------
  init_entry_t ob;

  always_comb begin
    ob      = '0;
    o_valid = 1'b0;
    case (state_q)
      ST_SLPOUT: begin
        o_valid = 1'b1;
        ob.dc   = 1'b0;
        ob.data = CMD_SLPOUT;
      end
      ST_INIT: begin
        o_valid = 1'b1;
        ob      = init_entry(idx_q);
      end
      ST_CASET: begin
        o_valid = 1'b1;
        ob      = addr_entry(CMD_CASET, idx_q, x0_q, x1_q);
      end
      ST_PASET: begin
        o_valid = 1'b1;
        ob      = addr_entry(CMD_PASET, idx_q, y0_q, y1_q);
      end
      ST_RAMWR: begin
        o_valid = 1'b1;
        ob.dc   = 1'b0;
        ob.data = CMD_RAMWR;
      end
      ST_PIXELS: begin
        o_valid = 1'b1;
        ob.dc   = 1'b1;
        ob.data = half_q ? color_q[7:0] : color_q[15:8];
      end
      default: ;
    endcase
  end

  assign o_data    = ob.data;
  assign o_dc      = ob.dc;
  assign xfer      = o_valid && i_ready;
  assign o_lcd_rst = (state_q != ST_RST_LOW);
  assign o_led     = led_q;
  // FINISH is the done cycle; busy already drops there.
  assign o_busy    = !((state_q == ST_IDLE) || (state_q == ST_FINISH));
  assign o_done    = (state_q == ST_FINISH);
  assign o_err     = (state_q == ST_FINISH) && err_q;

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    half_d   = half_q;
    pix_d    = pix_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    color_d  = color_q;
    err_d    = err_q;
    led_d    = led_q;
    tmr_load = 1'b0;

    case (state_q)
      ST_RST_LOW: begin
        if (tmr_expired) begin
          state_d  = ST_RST_HIGH;
          tmr_load = 1'b1;
        end
      end
      ST_RST_HIGH: begin
        if (tmr_expired) state_d = ST_SLPOUT;
      end
      ST_SLPOUT: begin
        if (xfer) begin
          state_d  = ST_SLP_WAIT;
          tmr_load = 1'b1;
        end
      end
      ST_SLP_WAIT: begin
        if (tmr_expired) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      ST_INIT: begin
        if (xfer) begin
          if (idx_q == 3'(INIT_LEN - 1)) begin
            idx_d   = '0;
            led_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_IDLE: begin
        if (i_start) begin
          x0_d    = i_x;
          y0_d    = i_y;
          x1_d    = x1_full[15:0];
          y1_d    = y1_full[15:0];
          color_d = i_color;
          pix_d   = pix_total;
          err_d   = reject;
          idx_d   = '0;
          half_d  = 1'b0;
          state_d = reject ? ST_FINISH : ST_CASET;
        end
      end
      ST_CASET, ST_PASET: begin
        if (xfer) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = (state_q == ST_CASET) ? ST_PASET : ST_RAMWR;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_RAMWR: begin
        if (xfer) state_d = ST_PIXELS;
      end
      ST_PIXELS: begin
        if (xfer) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            pix_d  = pix_q - PIX_W'(1);
            if (pix_q == PIX_W'(1)) state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_RST_LOW;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RST_LOW;
      idx_q   <= '0;
      half_q  <= 1'b0;
      pix_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      half_q  <= half_d;
      pix_q   <= pix_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: tb/tb_lcd_rect_sequencer.sv
// Directed bench for lcd_rect_sequencer (DELAY=20, 24x32 panel).
module tb_lcd_rect_sequencer;

  localparam int DELAY  = 20;
  localparam int WIDTH  = 24;
  localparam int HEIGHT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] x = '0, y = '0, w = '0, h = '0, color = '0;
  logic [7:0]  data;
  logic        dc, valid, lcd_rst, led, busy, done, err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [8:0] cap[$];
  logic [8:0] exp_q[$];
  int  done_c, last_c, stall_bad;
  bit  done_seen, err_seen, busy_at_done;

  lcd_rect_sequencer #(.DELAY(DELAY), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_x       (x),
    .i_y       (y),
    .i_w       (w),
    .i_h       (h),
    .i_color   (color),
    .o_data    (data),
    .o_dc      (dc),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_lcd_rst (lcd_rst),
    .o_led     (led),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble the inputs so any
  // failure to latch on the accepting cycle shows up in the byte stream.
  task automatic start_req(input logic [15:0] sx, sy, sw, sh, sc);
    x = sx; y = sy; w = sw; h = sh; color = sc;
    start = 1'b1;
    tick();
    start = 1'b0;
    x = 16'h00FF; y = 16'h00EE; w = 16'd0; h = 16'd7; color = 16'h5A5A;
  endtask

  // Record every transferred byte until o_done (or the budget runs out).
  task automatic capture(input bit toggle, input int budget);
    logic [8:0] held;
    bit stalled;
    cap.delete();
    done_seen = 0; err_seen = 0; busy_at_done = 1;
    done_c = -1; last_c = -1; stall_bad = 0;
    stalled = 0; held = '0;
    for (int c = 0; c < budget; c++) begin
      ready = toggle ? (c % 2 == 0) : 1'b1;
      if (stalled && (!valid || {dc, data} !== held)) stall_bad++;
      if (done) begin
        done_seen = 1; err_seen = err; done_c = c; busy_at_done = busy;
        break;
      end
      if (valid && ready) begin
        cap.push_back({dc, data});
        last_c  = c;
        stalled = 0;
      end else begin
        stalled = valid;
        held    = {dc, data};
      end
      tick();
    end
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({lcd_rst, valid, data, dc, busy, led, done, err} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_values: got rst=%b v=%b d=%h dc=%b busy=%b led=%b done=%b err=%b want 0 0 00 0 1 0 0 0",
               lcd_rst, valid, data, dc, busy, led, done, err);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  // Walks the init sequence starting in the first cycle after reset release.
  task automatic test_init();
    int n;
    n = 0;
    while (lcd_rst !== 1'b1 && n < 200) begin n++; tick(); end
    total_cnt++;
    if (n !== DELAY) $display("FAIL rst_low_len: got %0d want %0d", n, DELAY); else pass_cnt++;
    n = 0;
    while (valid !== 1'b1 && n < 200) begin n++; tick(); end
    total_cnt++;
    if (n !== DELAY) $display("FAIL rst_high_len: got %0d want %0d", n, DELAY); else pass_cnt++;
    total_cnt++;
    if ({dc, data} !== 9'h011) $display("FAIL slpout: got dc=%b %h want dc=0 11", dc, data); else pass_cnt++;
    tick();
    n = 0;
    while (valid !== 1'b1 && n < 200) begin n++; tick(); end
    total_cnt++;
    if (n !== DELAY) $display("FAIL slp_wait_len: got %0d want %0d", n, DELAY); else pass_cnt++;
    total_cnt++;
    if ({dc, data} !== 9'h03A) $display("FAIL init_colmod: got dc=%b %h want dc=0 3a", dc, data); else pass_cnt++;
    tick();
    total_cnt++;
    if ({valid, dc, data} !== 10'h355) $display("FAIL init_arg: got v=%b dc=%b %h want v=1 dc=1 55", valid, dc, data); else pass_cnt++;
    tick();
    total_cnt++;
    if ({valid, dc, data, led} !== 11'h452) $display("FAIL init_dispon: got v=%b dc=%b %h led=%b want v=1 dc=0 29 led=0", valid, dc, data, led); else pass_cnt++;
    tick();
    total_cnt++;
    if ({led, busy, valid} !== 3'b100) $display("FAIL init_done: got led=%b busy=%b valid=%b want 1 0 0", led, busy, valid); else pass_cnt++;
  endtask

  // Compare a captured request stream against exp_q and the done timing.
  task automatic check_stream(input string name);
    total_cnt++;
    if (cap.size() !== exp_q.size())
      $display("FAIL %s_len: got %0d bytes want %0d", name, cap.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      total_cnt++;
      if (cap[i] !== exp_q[i])
        $display("FAIL %s_byte%0d: got dc=%b %h want dc=%b %h", name, i, cap[i][8], cap[i][7:0], exp_q[i][8], exp_q[i][7:0]);
      else pass_cnt++;
    end
    total_cnt++;
    if (!done_seen || err_seen || done_c !== last_c + 1 || busy_at_done)
      $display("FAIL %s_done: got seen=%b err=%b at=%0d last=%0d busy=%b want seen=1 err=0 at=last+1 busy=0",
               name, done_seen, err_seen, done_c, last_c, busy_at_done);
    else pass_cnt++;
    total_cnt++;
    if (stall_bad !== 0) $display("FAIL %s_stall_hold: got %0d unstable stalls want 0", name, stall_bad); else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL %s_after_done: got done=%b busy=%b want 0 0", name, done, busy); else pass_cnt++;
  endtask

  task automatic test_request(input bit toggle);
    exp_q = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h103,
              9'h02B, 9'h100, 9'h103, 9'h100, 9'h104, 9'h02C,
              9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100, 9'h1F8, 9'h100};
    start_req(16'd2, 16'd3, 16'd2, 16'd2, 16'hF800);
    total_cnt++;
    if ({busy, valid, dc, data} !== 11'h62A) $display("FAIL req_start: got busy=%b v=%b dc=%b %h want 1 1 0 2a", busy, valid, dc, data); else pass_cnt++;
    capture(toggle, 200);
    check_stream(toggle ? "req_stall" : "req");
  endtask

  task automatic test_reject(input logic [15:0] sx, sw, input string name);
    start_req(sx, 16'd0, sw, 16'd1, 16'hFFFF);
    capture(1'b0, 20);
    total_cnt++;
    if (!done_seen || !err_seen || done_c !== 0 || cap.size() !== 0)
      $display("FAIL %s: got done=%b err=%b at=%0d bytes=%0d want 1 1 0 0", name, done_seen, err_seen, done_c, cap.size());
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({done, err, busy, valid} !== 4'b0000) $display("FAIL %s_after: got done=%b err=%b busy=%b v=%b want 0 0 0 0", name, done, err, busy, valid); else pass_cnt++;
  endtask

  task automatic test_overflow();
`ifdef LCD_SEQ_CLIP_EN
    exp_q = '{9'h02A, 9'h100, 9'h114, 9'h100, 9'h117,
              9'h02B, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02C,
              9'h112, 9'h134, 9'h112, 9'h134, 9'h112, 9'h134, 9'h112, 9'h134};
    start_req(16'd20, 16'd0, 16'd10, 16'd1, 16'h1234);
    capture(1'b0, 200);
    check_stream("clip");
`else
    test_reject(16'd20, 16'd10, "ovf_reject");
`endif
  endtask

  task automatic test_reset_midop();
    int ndone;
    ndone = 0;
    start_req(16'd0, 16'd0, 16'd4, 16'd4, 16'hABCD);
    // A second strobe while busy must be ignored (w=0 would reject).
    start = 1'b1; w = 16'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (done || err) ndone++;
      tick();
    end
    total_cnt++;
    if (ndone !== 0 || {busy, valid, dc} !== 3'b111)
      $display("FAIL busy_ignore: got pulses=%0d busy=%b v=%b dc=%b want 0 1 1 1", ndone, busy, valid, dc);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({valid, lcd_rst, led, busy} !== 4'b0001)
      $display("FAIL midop_reset: got v=%b lcd_rst=%b led=%b busy=%b want 0 0 0 1", valid, lcd_rst, led, busy);
    else pass_cnt++;
    rst = 1'b0;
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_request(1'b0);
    test_request(1'b1);
    test_reject(16'd2, 16'd0, "reject_w0");
    test_reject(16'd24, 16'd1, "reject_x");
    test_overflow();
    test_reset_midop();
    test_request(1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
